// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and the data stage (DM).
// Each access runs IDLE -> ISSUE -> [WAIT] -> RESP; DM has priority unless IF has been starved.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [1:0]        dbgState
);

    // Handshake: a requester raises its request and holds it until the one-cycle ack;
    // requests are only sampled in IDLE, so a request still high during RESP is picked up
    // in the following IDLE cycle.

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arbStateT;

    arbStateT            state;
    arbStateT            nextState;
    logic [STARVE_W-1:0] starveCnt;
    logic [3:0]          waitCnt;
    logic                ownerIf;
    logic                isWrite;

    logic dmReq;
    logic forceIf;
    logic grantDm;
    logic grantIf;
    logic lastWait;

    assign dmReq    = dm_rd | dm_wr;
    assign forceIf  = if_req && (starveCnt == STARVE_W'(STARVE_MAX));
    assign grantDm  = dmReq && !forceIf;
    assign grantIf  = if_req && !grantDm;
    assign lastWait = (waitCnt == 4'(MEM_LAT - 1));

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dmReq & ~dm_ack;
    assign dbgState  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (grantDm || grantIf) nextState = ISSUE;
            ISSUE:   nextState = isWrite ? RESP : WAIT;
            WAIT:    if (lastWait) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Registered datapath: acks are set on the edge entering RESP so they are high during RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            starveCnt <= '0;
            waitCnt   <= '0;
            ownerIf   <= 1'b0;
            isWrite   <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantDm) begin
                        // A simultaneous rd+wr is a write; the read half is dropped.
                        ownerIf   <= 1'b0;
                        isWrite   <= dm_wr;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_wr;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        if (if_req && (starveCnt != STARVE_W'(STARVE_MAX))) begin
                            starveCnt <= starveCnt + STARVE_W'(1);
                        end
                    end else if (grantIf) begin
                        ownerIf   <= 1'b1;
                        isWrite   <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        starveCnt <= '0;
                    end
                end
                ISSUE: begin
                    waitCnt <= '0;
                    if (isWrite) dm_ack <= 1'b1;
                end
                WAIT: begin
                    if (lastWait) begin
                        if (ownerIf) begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end else begin
                            dm_rdata <= mem_rdata;
                            dm_ack   <= 1'b1;
                        end
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single-access vector table, a simultaneous IF/DM
// sequence, IF starvation recovery, and reset in the middle of a read.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          dm_rd;
    logic          dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic [1:0]    dbgState;

    int checks = 0;
    int errors = 0;

    logic [31:0] ifShadow;
    logic [31:0] dmShadow;

    // Expected events for the multi-requester sequences.
    logic [63:0] exp_q[$];   // {isIf, ackCycle[30:0], rdata}
    logic [79:0] expEn_q[$]; // {enCycle[14:0], we, addr, wdata-or-0}

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
        .dbgState(dbgState)
    );

    // Memory contents: one special word, otherwise {addr[15:0], ~addr[15:0]}.
    function automatic logic [31:0] memFn(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C010004;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Two-cycle read pipeline; outside the valid slot the bus carries a poison value.
    logic        p1v, p2v;
    logic [31:0] p1d, p2d;
    always @(posedge clk) begin
        p1v <= mem_en && !mem_we;
        p1d <= memFn(mem_addr);
        p2v <= p1v;
        p2d <= p1d;
    end
    assign mem_rdata = p2v ? p2d : 32'hBAD0BAD0;

    typedef struct {
        bit          isIf;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          expLat;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chkReset(input string name);
        chk({name, " mem_en"}, 80'(mem_en), 80'd0);
        chk({name, " mem_we"}, 80'(mem_we), 80'd0);
        chk({name, " if_ack"}, 80'(if_ack), 80'd0);
        chk({name, " dm_ack"}, 80'(dm_ack), 80'd0);
        chk({name, " mem_addr"}, 80'(mem_addr), 80'd0);
        chk({name, " mem_wdata"}, 80'(mem_wdata), 80'd0);
        chk({name, " if_rdata"}, 80'(if_rdata), 80'd0);
        chk({name, " dm_rdata"}, 80'(dm_rdata), 80'd0);
        chk({name, " state"}, 80'(dbgState), 80'd0);
    endtask

    // One access from an idle arbiter; cycle 0 is the first cycle the request is visible.
    task automatic runTxn(input vec_t v, input string name);
        int          ackC, enC, enCnt;
        logic        enWe, ownAck, ownStall, expWe;
        logic [31:0] enAddr, enWd;
        ackC = -1; enC = -1; enCnt = 0; enWe = 1'b0; enAddr = '0; enWd = '0;
        expWe = v.isIf ? 1'b0 : v.wr;
        @(posedge clk); #1;
        if (v.isIf) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            dm_rd = v.rd; dm_wr = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
        end
        for (int c = 0; c < 40 && ackC < 0; c++) begin
            @(negedge clk);
            if (mem_en) begin
                enCnt++;
                if (enC < 0) begin
                    enC = c; enWe = mem_we; enAddr = mem_addr; enWd = mem_wdata;
                end
            end
            ownAck   = v.isIf ? if_ack : dm_ack;
            ownStall = v.isIf ? stall_if : stall_mem;
            if (ownAck) begin
                ackC = c;
                chk({name, " stall at ack"}, 80'(ownStall), 80'd0);
                chk({name, " other ack"}, 80'(v.isIf ? dm_ack : if_ack), 80'd0);
                chk({name, " rdata"}, 80'(v.isIf ? if_rdata : dm_rdata), 80'(v.expData));
                chk({name, " other rdata"}, 80'(v.isIf ? dm_rdata : if_rdata),
                    80'(v.isIf ? dmShadow : ifShadow));
            end else begin
                chk({name, " stall"}, 80'(ownStall), 80'd1);
                @(posedge clk);
            end
        end
        chk({name, " ack cycle"}, 80'(ackC), 80'(v.expLat));
        chk({name, " mem_en cycle"}, 80'(enC), 80'd1);
        chk({name, " mem_en count"}, 80'(enCnt), 80'd1);
        chk({name, " mem_we"}, 80'(enWe), 80'(expWe));
        chk({name, " mem_addr"}, 80'(enAddr), 80'(v.addr));
        if (expWe) chk({name, " mem_wdata"}, 80'(enWd), 80'(v.wdata));
        if (v.isIf) ifShadow = v.expData;
        else        dmShadow = v.expData;
        @(posedge clk); #1;
        if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
        @(negedge clk);
        chk({name, " ack width"}, 80'(v.isIf ? if_ack : dm_ack), 80'd0);
    endtask

    // Concurrent IF/DM traffic checked against exp_q / expEn_q. DM re-requests with
    // addresses stepping by 4 until dmCount accesses are acked.
    task automatic runMixed(input bit ifOn, input logic [31:0] ifA, input int dmCount,
                            input bit dmWr, input logic [31:0] dmA0, input logic [31:0] dmWd,
                            input int maxCyc, input string name);
        int          dmIdx;
        bit          ifDone, dmAcked;
        logic [63:0] expv;
        logic [79:0] expE;
        dmIdx = 0; ifDone = 1'b0;
        @(posedge clk); #1;
        if_req = ifOn; if_addr = ifA;
        dm_rd = (dmCount > 0) && !dmWr; dm_wr = (dmCount > 0) && dmWr;
        dm_addr = dmA0; dm_wdata = dmWd;
        for (int c = 0; c < maxCyc && (exp_q.size() > 0 || expEn_q.size() > 0); c++) begin
            @(negedge clk);
            dmAcked = 1'b0;
            if (mem_en) begin
                if (expEn_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s unexpected mem_en: cycle %0d addr 0x%08h", name, c, mem_addr);
                end else begin
                    expE = expEn_q.pop_front();
                    chk({name, " mem_en event"},
                        {15'(c), mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)}, expE);
                end
            end
            if (if_ack || dm_ack) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s unexpected ack: cycle %0d if %0b dm %0b", name, c, if_ack, dm_ack);
                end else begin
                    expv = exp_q.pop_front();
                    chk({name, " ack event"},
                        80'({if_ack, 31'(c), (if_ack ? if_rdata : dm_rdata)}), 80'(expv));
                end
                if (if_ack) ifDone = 1'b1;
                if (dm_ack) begin dmIdx++; dmAcked = 1'b1; end
            end
            @(posedge clk); #1;
            if (ifDone) if_req = 1'b0;
            if (dmAcked) begin
                if (dmIdx < dmCount) dm_addr = dmA0 + 32'(4 * dmIdx);
                else begin dm_rd = 1'b0; dm_wr = 1'b0; end
            end
        end
        while (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL %s ack timeout: got none, expected 0x%0h", name, expv);
        end
        while (expEn_q.size() > 0) begin
            expE = expEn_q.pop_front();
            checks++; errors++;
            $display("FAIL %s mem_en timeout: got none, expected 0x%0h", name, expE);
        end
        if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    endtask

    initial begin
        int ackSeen;
        logic [31:0] a;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40,   32'h0,        4, 32'h8C010004};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h80,   32'h0,        4, 32'h0080FF7F};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h100,  32'hDEADBEEF, 2, 32'h0080FF7F};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h1234, 32'h0,        4, 32'h1234EDCB};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h10,   32'h0,        4, 32'h0010FFEF};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h10,   32'h5,        2, 32'h0010FFEF};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'hFFFC, 32'h0,        4, 32'hFFFC0003};

        // Clock/reset
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0;
        dm_addr = '0; dm_wdata = '0;
        ifShadow = '0; dmShadow = '0;
        repeat (2) @(posedge clk);
        #1;
        chkReset("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            runTxn(vecs[i], $sformatf("vec%0d", i));
        end

        // IF and DM store together: DM first, IF issued once the store completes.
        exp_q.push_back({1'b0, 31'd2, dmShadow});
        exp_q.push_back({1'b1, 31'd7, 32'h0000FFFF});
        expEn_q.push_back({15'd1, 1'b1, 32'h100, 32'hDEADBEEF});
        expEn_q.push_back({15'd4, 1'b0, 32'h0, 32'h0});
        runMixed(1'b1, 32'h0, 1, 1'b1, 32'h100, 32'hDEADBEEF, 30, "simul");
        ifShadow = 32'h0000FFFF;

        // IF starvation: four DM loads, then IF, then DM again.
        for (int k = 0; k < 4; k++) begin
            a = 32'h200 + 32'(4 * k);
            exp_q.push_back({1'b0, 31'(4 + 5 * k), memFn(a)});
            expEn_q.push_back({15'(1 + 5 * k), 1'b0, a, 32'h0});
        end
        exp_q.push_back({1'b1, 31'd24, memFn(32'h300)});
        expEn_q.push_back({15'd21, 1'b0, 32'h300, 32'h0});
        for (int k = 4; k < 6; k++) begin
            a = 32'h200 + 32'(4 * k);
            exp_q.push_back({1'b0, 31'(9 + 5 * k), memFn(a)});
            expEn_q.push_back({15'(6 + 5 * k), 1'b0, a, 32'h0});
        end
        runMixed(1'b1, 32'h300, 6, 1'b0, 32'h200, 32'h0, 60, "starve");
        ifShadow = memFn(32'h300);
        dmShadow = memFn(32'h214);

        // Reset for two cycles while a DM read sits in WAIT with IF also pending.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h44; dm_rd = 1'b1; dm_addr = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        chkReset("mid reset");
        rst = 1'b0; if_req = 1'b0; dm_rd = 1'b0;
        ackSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (if_ack || dm_ack) ackSeen++;
        end
        chk("post-reset acks", 80'(ackSeen), 80'd0);
        chk("post-reset dm_rdata", 80'(dm_rdata), 80'd0);
        chk("post-reset if_rdata", 80'(if_rdata), 80'd0);
        chk("post-reset state", 80'(dbgState), 80'd0);
        ifShadow = '0; dmShadow = '0;
        runTxn('{1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 4, 32'h0400FBFF}, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
